psum_route_ctrl: RTL and testbench
==================================

Name: psum_route_ctrl

Overview:
- Clocked sequencer directly upstream of the PE split stage in the 1-D convolution PE.
- Receives the accumulator's partial-sum stream and tags every word with a 2-bit route select: 2'b01 recirculates the word to the accumulator, 2'b10 sends it out as a finished output.
- Tracks filter taps and output count per run. Presents data and select together on one registered output slot, so the split receives both in the same transfer.

Parameters:
- WIDTH, 8, partial-sum data width.
- MAX_TAPS, 5, largest filter length supported; tap counter width is $clog2(MAX_TAPS+1).
- MAX_OUTS, 16, largest output count per run; output counter width is $clog2(MAX_OUTS+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches configuration and begins a run.
- cfg_taps  in  $clog2(MAX_TAPS+1)  taps per output; sampled on start.
- cfg_outs  in  $clog2(MAX_OUTS+1)  outputs per run; sampled on start.
- in_valid  in  1  partial sum available.
- in_ready  out  1  block accepts partial sum.
- in_data  in  WIDTH  partial sum.
- out_valid  out  1  data/sel pair available to split.
- out_ready  in  1  split accepts pair.
- out_data  out  WIDTH  registered partial sum.
- out_sel  out  2  route select: 01 = recirculate, 10 = final output.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when run completes.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; tap_cnt=0; out_cnt=0; out slot empty.
  - Outputs: out_valid=0, out_data=0, out_sel=2'b00, in_ready=0, busy=0, done=0.
  - An in-flight word is discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - On start, latch taps_q=cfg_taps and outs_q=cfg_outs, then go to RUN.
  - Clamping: cfg_taps of 0 becomes 1; cfg_taps above MAX_TAPS becomes MAX_TAPS. The same rule applies to cfg_outs against MAX_OUTS.
- RUN:
  - in_ready = !slot_full || out_ready. This is a single-entry pipeline register with full throughput: a simultaneous input accept and output accept on a full slot reloads it in the same cycle.
  - On input accept (in_valid && in_ready), load out_data=in_data.
  - If tap_cnt==taps_q-1: out_sel=2'b10, tap_cnt wraps to 0, out_cnt increments.
  - Otherwise: out_sel=2'b01, tap_cnt increments.
  - The accept that makes out_cnt==outs_q moves the FSM to DRAIN.
- DRAIN:
  - in_ready=0.
  - Wait until the slot empties (out_valid && out_ready, or already empty), then go to DONE.
- DONE:
  - done=1 for exactly one cycle; clear tap_cnt and out_cnt; go to IDLE.
- Latency: an accepted input appears on out_valid the next cycle.
- Output stability: out_valid, once high, stays high with out_data and out_sel unchanged until out_ready.
- start outside IDLE is ignored; configuration is not relatched mid-run.
- taps_q==1: every word gets out_sel=2'b10.
- in_valid while in_ready=0 has no effect and consumes no data.
- busy = (state==RUN || state==DRAIN).
- out_sel is never 2'b00 or 2'b11 while out_valid=1.

Test Plan:
- Basic run:
  - Stimulus: cfg_taps=3, cfg_outs=2, start; inputs 10,11,12,13,14,15 with out_ready=1.
  - Required: sel sequence 01,01,10,01,01,10; data matches; done pulses one cycle after the last transfer; busy falls with it.
- Backpressure:
  - Stimulus: cfg_taps=2, cfg_outs=2; hold out_ready=0 for 4 cycles after the first accept.
  - Required: in_ready=0 while the slot is full; out_data and out_sel stay stable; no word is lost or duplicated.
- Full throughput:
  - Stimulus: continuous in_valid and out_ready.
  - Required: one transfer per cycle, no bubbles, 2-cycle latency from start to the first out_valid.
- Clamping:
  - Stimulus: cfg_taps=0, cfg_outs=3.
  - Required: all three outputs have sel=10, then done.
  - Stimulus: cfg_taps=7 with MAX_TAPS=5.
  - Required: a 10 every fifth word.
- Reset mid-run:
  - Stimulus: assert rst asynchronously (between clock edges) after 2 of 5 taps with the slot full.
  - Required: out_valid, busy and in_ready drop immediately. A new start with cfg_taps=2 gives sel 01,10 from tap 0.
- Start during RUN:
  - Stimulus: pulse start with different cfg values while RUN is active.
  - Required: the original taps_q and outs_q are kept and done timing is unchanged.

Source files
------------

// File: rtl/psum_route_ctrl.sv
// Route-select sequencer ahead of the PE split stage: each accepted partial sum is tagged
// recirculate (01) or final (10) and held with its tag in one registered output slot.
module psum_route_ctrl #(
    parameter int WIDTH    = 8,
    parameter int MAX_TAPS = 5,
    parameter int MAX_OUTS = 16,
    localparam int TW      = $clog2(MAX_TAPS + 1),
    localparam int OW      = $clog2(MAX_OUTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TW-1:0]    cfg_taps,
    input  logic [OW-1:0]    cfg_outs,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_sel,
    output logic             busy,
    output logic             done
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // a valid source holds data stable until that edge and never waits on ready to raise valid.

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_d;
    logic [TW-1:0] taps_q;
    logic [TW-1:0] tap_cnt;
    logic [OW-1:0] outs_q;
    logic [OW-1:0] out_cnt;
    logic          accept;
    logic          out_fire;
    logic          last_tap;
    logic          last_out;

    function automatic logic [TW-1:0] clamp_taps(input logic [TW-1:0] v);
        if (v == '0)
            return TW'(1);
        else if (v > TW'(MAX_TAPS))
            return TW'(MAX_TAPS);
        else
            return v;
    endfunction

    function automatic logic [OW-1:0] clamp_outs(input logic [OW-1:0] v);
        if (v == '0)
            return OW'(1);
        else if (v > OW'(MAX_OUTS))
            return OW'(MAX_OUTS);
        else
            return v;
    endfunction

    // Single-entry slot with full throughput: a full slot that is draining may reload at once.
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_tap = (tap_cnt == taps_q - TW'(1));
    assign last_out = (out_cnt + OW'(1) == outs_q);

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (accept && last_tap && last_out)
                    state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!out_valid || out_ready)
                    state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            taps_q  <= TW'(1);
            outs_q  <= OW'(1);
            tap_cnt <= '0;
            out_cnt <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && start) begin
                taps_q <= clamp_taps(cfg_taps);
                outs_q <= clamp_outs(cfg_outs);
            end
            if (state == DONE) begin
                tap_cnt <= '0;
                out_cnt <= '0;
            end else if (accept) begin
                if (last_tap) begin
                    tap_cnt <= '0;
                    out_cnt <= out_cnt + OW'(1);
                end else begin
                    tap_cnt <= tap_cnt + TW'(1);
                end
            end
        end
    end

    // Data and its route select always load together so the split sees them as one transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'b00;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_sel   <= last_tap ? 2'b10 : 2'b01;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_psum_route_ctrl.sv
// Randomized bench for psum_route_ctrl: a queue-based route model feeds a scoreboard that a
// separate monitor drains on every output transfer.
module tb_psum_route_ctrl;

    localparam int WIDTH    = 8;
    localparam int MAX_TAPS = 5;
    localparam int MAX_OUTS = 16;
    localparam int TW       = $clog2(MAX_TAPS + 1);
    localparam int OW       = $clog2(MAX_OUTS + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [TW-1:0]    cfg_taps = '0;
    logic [OW-1:0]    cfg_outs = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             busy;
    logic             done;

    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH+1:0] exp_word;
    int               tests = 0;
    int               fails = 0;
    int               popped = 0;
    int               run_words = 0;
    bit               all_popped = 1'b0;
    bit               hold = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic [1:0]       prev_sel = '0;

    psum_route_ctrl #(
        .WIDTH(WIDTH),
        .MAX_TAPS(MAX_TAPS),
        .MAX_OUTS(MAX_OUTS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_taps(cfg_taps),
        .cfg_outs(cfg_outs),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sel(out_sel),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples between edges, pops the scoreboard on every output transfer.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_sel", 32'(out_sel), 32'(prev_sel));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got sel=%b data=%0d, required no output", out_sel, out_data);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("out_sel", 32'(out_sel), 32'(exp_word[WIDTH+1:WIDTH]));
                    check("out_data", 32'(out_data), 32'(exp_word[WIDTH-1:0]));
                    popped++;
                    if (popped == run_words)
                        all_popped = 1'b1;
                end
            end
            hold      = out_valid && !out_ready;
            prev_data = out_data;
            prev_sel  = out_sel;
        end
    end

    // One run: mode 0 full throughput, 1 random valid/ready, 2 fixed backpressure, 3 data 10,11,...
    task automatic run(input int taps, input int outs, input int mode, input bit poke);
        int t;
        int o;
        int n;
        int k;
        int cyc;
        logic [1:0] sel;
        t = (taps == 0) ? 1 : ((taps > MAX_TAPS) ? MAX_TAPS : taps);
        o = (outs == 0) ? 1 : ((outs > MAX_OUTS) ? MAX_OUTS : outs);
        n = t * o;
        k = 0;
        cyc = 0;
        exp_q.delete();
        popped = 0;
        run_words = n;
        all_popped = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cfg_taps = TW'(taps);
        cfg_outs = OW'(outs);
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        while (!all_popped && cyc < 400) begin
            start = 1'b0;
            if (poke && cyc == 3) begin
                start = 1'b1;
                cfg_taps = TW'(1);
                cfg_outs = OW'(9);
            end
            in_data = WIDTH'($urandom_range(0, 255));
            case (mode)
                0: begin
                    in_valid = (k < n) ? 1'b1 : 1'($urandom_range(0, 1));
                    out_ready = 1'b1;
                end
                1: begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                2: begin
                    in_valid = 1'b1;
                    out_ready = !(cyc >= 1 && cyc <= 4);
                end
                default: begin
                    in_valid = (k < n);
                    in_data = WIDTH'(10 + k);
                    out_ready = 1'b1;
                end
            endcase
            #1;
            check("busy_run", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            check("in_ready", 32'(in_ready), 32'((k < n) && (exp_q.size() == 0 || out_ready)));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (in_valid && in_ready) begin
                sel = ((k % t) == t - 1) ? 2'b10 : 2'b01;
                exp_q.push_back({sel, in_data});
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        if (!all_popped) begin
            tests++;
            fails++;
            $display("FAIL run_timeout: got %0d of %0d words, required all within 400 cycles", popped, n);
        end
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("in_ready_done", 32'(in_ready), 32'd0);
        check("out_valid_done", 32'(out_valid), 32'd0);
        check("leftover", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic reset_mid_run();
        exp_q.delete();
        popped = 0;
        run_words = 1000;
        all_popped = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cfg_taps = TW'(5);
        cfg_outs = OW'(2);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b1;
            in_data = WIDTH'(8'h21 + i);
            #1;
            check("rst_pre_in_ready", 32'(in_ready), 32'd1);
            if (in_valid && in_ready)
                exp_q.push_back({2'b01, in_data});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_slot_full", 32'(out_valid), 32'd1);
        check("rst_full_in_ready", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        hold = 1'b0;
        exp_q.delete();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_sel", 32'(out_sel), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(3, 2, 3, 1'b0);
        run(2, 2, 2, 1'b0);
        run(4, 3, 0, 1'b0);
        run(0, 3, 0, 1'b0);
        run(7, 2, 1, 1'b0);
        run(1, 31, 0, 1'b0);
        run(3, 0, 1, 1'b0);
        run(2, 3, 0, 1'b1);
        reset_mid_run();
        run(2, 1, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            run($urandom_range(0, 7), $urandom_range(0, 6), 1, 1'($urandom_range(0, 1)));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
